// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose:
//   Bundles the request/response handshakes of the two cache masters and the
//   single off-chip memory port that the arbiter shares between them.
//
// Signals (names are from the arbiter's point of view):
//   m0_enable_i / m1_enable_i : cache request, held until its ack is seen
//   m0_write_i  / m1_write_i  : 1 = line write, 0 = line read
//   m0_addr_i   / m1_addr_i   : line address
//   m0_data_i   / m1_data_i   : write line
//   m0_ack_o    / m1_ack_o    : one-cycle completion pulse
//   m0_data_o   / m1_data_o   : read line, valid while the ack is high
//   mem_enable_o / mem_write_o / mem_addr_o / mem_data_o : memory request
//   mem_ack_i / mem_data_i    : memory completion and read line
//
// Modports:
//   slave  : the arbiter itself
//   master : the surroundings (caches plus memory model)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
);
    logic              m0_enable_i;
    logic              m0_write_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_data_i;
    logic              m0_ack_o;
    logic [DATA_W-1:0] m0_data_o;

    logic              m1_enable_i;
    logic              m1_write_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_data_i;
    logic              m1_ack_o;
    logic [DATA_W-1:0] m1_data_o;

    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_data_i;

    modport slave (
        input  m0_enable_i, m0_write_i, m0_addr_i, m0_data_i,
        output m0_ack_o, m0_data_o,
        input  m1_enable_i, m1_write_i, m1_addr_i, m1_data_i,
        output m1_ack_o, m1_data_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_ack_i, mem_data_i
    );

    modport master (
        output m0_enable_i, m0_write_i, m0_addr_i, m0_data_i,
        input  m0_ack_o, m0_data_o,
        output m1_enable_i, m1_write_i, m1_addr_i, m1_data_i,
        input  m1_ack_o, m1_data_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_ack_i, mem_data_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one whole-line memory port between two cache masters. Requests are
//   served one complete line transaction at a time, contested requests are
//   resolved round-robin, every memory-side output comes straight from a
//   register, and a watchdog gives up on a memory that never answers.
//
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-high reset; abandons any transaction
//   bus       : slave side of mem_port_arbiter_if (both masters + memory)
//   grant_o   : one-hot owner (bit 0 = m0, bit 1 = m1), 00 while idle
//   timeout_o : sticky flag, set when the watchdog fires, cleared by reset
//
// Parameters:
//   ADDR_W, DATA_W : must match the widths of the connected interface
//   TIMEOUT        : cycles allowed in BUSY waiting for mem_ack_i; 0 = off
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    mem_port_arbiter_if.slave         bus,
    output logic [1:0]                grant_o,
    output logic                      timeout_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    // The counter must be able to hold TIMEOUT itself because it saturates
    // there; the watchdog fires one step earlier so that exactly TIMEOUT BUSY
    // cycles elapse before the owner is released.
    localparam int               CNT_W       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(TIMEOUT);
    localparam bit               WATCHDOG_EN = (TIMEOUT != 0);

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic                preferM1_q, preferM1_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                timeout_q, timeout_d;
    logic                memEnable_q, memEnable_d;
    logic                memWrite_q, memWrite_d;
    logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
    logic [DATA_W-1:0]   memData_q, memData_d;
    logic                m0Ack_q, m0Ack_d;
    logic                m1Ack_q, m1Ack_d;
    logic [DATA_W-1:0]   m0Data_q, m0Data_d;
    logic [DATA_W-1:0]   m1Data_q, m1Data_d;
    logic                pickM1;

    // State and output registers. Reset drops everything at once, including
    // a transaction in flight, so no ack can escape after reset is seen.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            preferM1_q  <= 1'b0;
            count_q     <= '0;
            timeout_q   <= 1'b0;
            memEnable_q <= 1'b0;
            memWrite_q  <= 1'b0;
            memAddr_q   <= '0;
            memData_q   <= '0;
            m0Ack_q     <= 1'b0;
            m1Ack_q     <= 1'b0;
            m0Data_q    <= '0;
            m1Data_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            preferM1_q  <= preferM1_d;
            count_q     <= count_d;
            timeout_q   <= timeout_d;
            memEnable_q <= memEnable_d;
            memWrite_q  <= memWrite_d;
            memAddr_q   <= memAddr_d;
            memData_q   <= memData_d;
            m0Ack_q     <= m0Ack_d;
            m1Ack_q     <= m1Ack_d;
            m0Data_q    <= m0Data_d;
            m1Data_q    <= m1Data_d;
        end
    end

    // Next-state logic. Everything holds by default except the acks, which
    // are single-cycle pulses and are only raised on the way into RESP.
    // preferM1_q records who should win the next tie: it points away from
    // whichever master was granted last, and favours m0 out of reset.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        preferM1_d  = preferM1_q;
        count_d     = count_q;
        timeout_d   = timeout_q;
        memEnable_d = memEnable_q;
        memWrite_d  = memWrite_q;
        memAddr_d   = memAddr_q;
        memData_d   = memData_q;
        m0Ack_d     = 1'b0;
        m1Ack_d     = 1'b0;
        m0Data_d    = m0Data_q;
        m1Data_d    = m1Data_q;
        pickM1      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.m0_enable_i || bus.m1_enable_i) begin
                    pickM1      = bus.m1_enable_i && (!bus.m0_enable_i || preferM1_q);
                    grant_d     = pickM1 ? 2'b10 : 2'b01;
                    preferM1_d  = !pickM1;
                    memEnable_d = 1'b1;
                    memWrite_d  = pickM1 ? bus.m1_write_i : bus.m0_write_i;
                    memAddr_d   = pickM1 ? bus.m1_addr_i  : bus.m0_addr_i;
                    memData_d   = pickM1 ? bus.m1_data_i  : bus.m0_data_i;
                    count_d     = '0;
                    state_d     = BUSY;
                end
            end

            BUSY: begin
                if (bus.mem_ack_i) begin
                    // Writes capture the read bus too; the master ignores it.
                    if (grant_q[0]) begin
                        m0Data_d = bus.mem_data_i;
                    end else begin
                        m1Data_d = bus.mem_data_i;
                    end
                    m0Ack_d     = grant_q[0];
                    m1Ack_d     = grant_q[1];
                    memEnable_d = 1'b0;
                    memWrite_d  = 1'b0;
                    state_d     = RESP;
                end else if (WATCHDOG_EN && (count_q == CNT_LAST)) begin
                    // Release the owner with its old data so it cannot hang;
                    // the write strobe is dropped with the enable since it
                    // means nothing on its own.
                    timeout_d   = 1'b1;
                    m0Ack_d     = grant_q[0];
                    m1Ack_d     = grant_q[1];
                    memEnable_d = 1'b0;
                    memWrite_d  = 1'b0;
                    state_d     = RESP;
                end else if (count_q != CNT_MAX) begin
                    count_d = count_q + 1'b1;
                end
            end

            RESP: begin
                // This cycle is also the mandatory enable-low gap for memory.
                grant_d = 2'b00;
                state_d = IDLE;
            end

            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    assign grant_o          = grant_q;
    assign timeout_o        = timeout_q;
    assign bus.mem_enable_o = memEnable_q;
    assign bus.mem_write_o  = memWrite_q;
    assign bus.mem_addr_o   = memAddr_q;
    assign bus.mem_data_o   = memData_q;
    assign bus.m0_ack_o     = m0Ack_q;
    assign bus.m1_ack_o     = m1Ack_q;
    assign bus.m0_data_o    = m0Data_q;
    assign bus.m1_data_o    = m1Data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Purpose:
//   Exercises the two-master memory port arbiter: reset state, single reads,
//   contested requests, back-to-back requests, request stability while busy,
//   randomized traffic, the response watchdog and reset during a transaction.
//   Expected values come from a small transaction-level model: who is owed
//   service, who was served last, and what each master last received.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 256;
    localparam int TIMEOUT = 16;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [1:0] grant_o;
    logic       timeout_o;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .bus      (bus),
        .grant_o  (grant_o),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model state.
    logic [DATA_W-1:0] expData [2];
    int                lastGrant;
    logic              expTimeout;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rand256();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic modelReset();
        expData[0] = '0;
        expData[1] = '0;
        lastGrant  = -1;
        expTimeout = 1'b0;
    endtask

    task automatic idleInputs();
        bus.m0_enable_i = 1'b0; bus.m0_write_i = 1'b0; bus.m0_addr_i = '0; bus.m0_data_i = '0;
        bus.m1_enable_i = 1'b0; bus.m1_write_i = 1'b0; bus.m1_addr_i = '0; bus.m1_data_i = '0;
        bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;
    endtask

    task automatic setReq(input int m, input logic en, input logic wr,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        if (m == 0) begin
            bus.m0_enable_i = en; bus.m0_write_i = wr; bus.m0_addr_i = addr; bus.m0_data_i = data;
        end else begin
            bus.m1_enable_i = en; bus.m1_write_i = wr; bus.m1_addr_i = addr; bus.m1_data_i = data;
        end
    endtask

    task automatic dropReq(input int m);
        if (m == 0) bus.m0_enable_i = 1'b0;
        else        bus.m1_enable_i = 1'b0;
    endtask

    task automatic applyReset();
        rst_i = 1'b1;
        idleInputs();
        tick();
        tick();
        rst_i = 1'b0;
        modelReset();
    endtask

    // Memory model: called just after the grant edge, answers so that the
    // enable is seen high for 'latency' cycles. Returns how many of those
    // cycles really had the enable high and how many showed any ack.
    task automatic memRespond(input int latency, input logic [DATA_W-1:0] rdata,
                              output int enCycles, output int ackSeen);
        enCycles = 0;
        ackSeen  = 0;
        bus.mem_ack_i = 1'b0;
        for (int i = 1; i <= latency; i++) begin
            if (bus.mem_enable_o) enCycles++;
            if (bus.m0_ack_o || bus.m1_ack_o) ackSeen++;
            if (i == latency) begin
                bus.mem_ack_i  = 1'b1;
                bus.mem_data_i = rdata;
            end
            tick();
        end
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = rand256();
    endtask

    task automatic test_reset();
        applyReset();
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b expected 00", grant_o); end
        checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
        checks++; if ({bus.mem_enable_o, bus.mem_write_o} !== 2'b00) begin failures++; $display("FAIL reset_mem_ctrl: got %b expected 00", {bus.mem_enable_o, bus.mem_write_o}); end
        checks++; if (bus.mem_addr_o !== '0) begin failures++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr_o); end
        checks++; if (bus.mem_data_o !== '0) begin failures++; $display("FAIL reset_mem_data: got %h expected 0", bus.mem_data_o); end
        checks++; if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b00) begin failures++; $display("FAIL reset_acks: got %b expected 00", {bus.m0_ack_o, bus.m1_ack_o}); end
        checks++; if ({bus.m0_data_o, bus.m1_data_o} !== '0) begin failures++; $display("FAIL reset_master_data: got %h/%h expected 0", bus.m0_data_o, bus.m1_data_o); end
        tick();
        checks++; if (bus.mem_enable_o !== 1'b0) begin failures++; $display("FAIL idle_no_request: mem_enable got %b expected 0", bus.mem_enable_o); end
    endtask

    task automatic test_single_read();
        logic [DATA_W-1:0] rd;
        int enC, ackS;
        rd = rand256();
        rd[7:0] = 8'hA5;
        setReq(0, 1'b1, 1'b0, 32'h0000_0400, rand256());
        checks++; if (bus.mem_enable_o !== 1'b0) begin failures++; $display("FAIL single_pre_enable: got %b expected 0", bus.mem_enable_o); end
        tick();
        checks++; if (bus.mem_enable_o !== 1'b1) begin failures++; $display("FAIL single_enable: got %b expected 1", bus.mem_enable_o); end
        checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL single_grant: got %b expected 01", grant_o); end
        checks++; if ({bus.mem_write_o, bus.mem_addr_o} !== {1'b0, 32'h0000_0400}) begin failures++; $display("FAIL single_req: got w=%b a=%h expected w=0 a=00000400", bus.mem_write_o, bus.mem_addr_o); end
        memRespond(10, rd, enC, ackS);
        checks++; if (enC !== 10) begin failures++; $display("FAIL single_enable_len: got %0d expected 10", enC); end
        checks++; if (ackS !== 0) begin failures++; $display("FAIL single_early_ack: got %0d expected 0", ackS); end
        checks++; if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b10) begin failures++; $display("FAIL single_ack: got m0=%b m1=%b expected m0=1 m1=0", bus.m0_ack_o, bus.m1_ack_o); end
        checks++; if (bus.m0_data_o !== rd) begin failures++; $display("FAIL single_data: got %h expected %h", bus.m0_data_o, rd); end
        checks++; if (bus.mem_enable_o !== 1'b0) begin failures++; $display("FAIL single_resp_enable: got %b expected 0", bus.mem_enable_o); end
        dropReq(0);
        expData[0] = rd;
        lastGrant  = 0;
        tick();
        checks++; if ({bus.m0_ack_o, grant_o} !== 3'b000) begin failures++; $display("FAIL single_idle: got ack=%b grant=%b expected 0/00", bus.m0_ack_o, grant_o); end
    endtask

    task automatic test_contention();
        logic [DATA_W-1:0] d0, r0, r1;
        int enC, ackS;
        applyReset();
        d0 = rand256(); r0 = rand256(); r1 = rand256();
        setReq(0, 1'b1, 1'b1, 32'h20, d0);
        setReq(1, 1'b1, 1'b0, 32'h40, rand256());
        tick();
        checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL contend_first: got %b expected 01", grant_o); end
        checks++; if ({bus.mem_write_o, bus.mem_addr_o, bus.mem_data_o} !== {1'b1, 32'h20, d0}) begin failures++; $display("FAIL contend_m0_req: got w=%b a=%h expected w=1 a=00000020", bus.mem_write_o, bus.mem_addr_o); end
        memRespond(3, r0, enC, ackS);
        checks++; if ({bus.m0_ack_o, bus.m1_ack_o, bus.mem_enable_o} !== 3'b100) begin failures++; $display("FAIL contend_resp0: got ack0=%b ack1=%b en=%b expected 1/0/0", bus.m0_ack_o, bus.m1_ack_o, bus.mem_enable_o); end
        dropReq(0);
        expData[0] = r0;
        tick();
        checks++; if ({bus.mem_enable_o, grant_o} !== 3'b000) begin failures++; $display("FAIL contend_gap: got en=%b grant=%b expected 0/00", bus.mem_enable_o, grant_o); end
        tick();
        checks++; if (grant_o !== 2'b10) begin failures++; $display("FAIL contend_second: got %b expected 10", grant_o); end
        checks++; if ({bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o} !== {2'b10, 32'h40}) begin failures++; $display("FAIL contend_m1_req: got en=%b w=%b a=%h expected 1/0/00000040", bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o); end
        memRespond(2, r1, enC, ackS);
        checks++; if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b01) begin failures++; $display("FAIL contend_resp1: got m0=%b m1=%b expected 0/1", bus.m0_ack_o, bus.m1_ack_o); end
        checks++; if ({bus.m0_data_o, bus.m1_data_o} !== {r0, r1}) begin failures++; $display("FAIL contend_data: got %h/%h expected %h/%h", bus.m0_data_o, bus.m1_data_o, r0, r1); end
        dropReq(1);
        expData[1] = r1;
        lastGrant  = 1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] dB, rA, rB, rC;
        int enC, ackS;
        dB = rand256(); rA = rand256(); rB = rand256(); rC = rand256();
        setReq(0, 1'b1, 1'b0, 32'hA000, rand256());
        tick();
        checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL b2b_first: got %b expected 01", grant_o); end
        setReq(1, 1'b1, 1'b1, 32'hB000, dB);
        memRespond(4, rA, enC, ackS);
        checks++; if (bus.m0_ack_o !== 1'b1) begin failures++; $display("FAIL b2b_ack_a: got %b expected 1", bus.m0_ack_o); end
        setReq(0, 1'b1, 1'b0, 32'hC000, rand256());
        expData[0] = rA;
        tick();
        tick();
        checks++; if (grant_o !== 2'b10) begin failures++; $display("FAIL b2b_rr: got %b expected 10", grant_o); end
        checks++; if ({bus.mem_write_o, bus.mem_addr_o, bus.mem_data_o} !== {1'b1, 32'hB000, dB}) begin failures++; $display("FAIL b2b_m1_req: got w=%b a=%h expected w=1 a=0000b000", bus.mem_write_o, bus.mem_addr_o); end
        memRespond(2, rB, enC, ackS);
        checks++; if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b01) begin failures++; $display("FAIL b2b_ack_b: got m0=%b m1=%b expected 0/1", bus.m0_ack_o, bus.m1_ack_o); end
        dropReq(1);
        expData[1] = rB;
        tick();
        tick();
        checks++; if ({grant_o, bus.mem_addr_o} !== {2'b01, 32'hC000}) begin failures++; $display("FAIL b2b_m0_again: got grant=%b a=%h expected 01/0000c000", grant_o, bus.mem_addr_o); end
        memRespond(1, rC, enC, ackS);
        checks++; if ({bus.m0_ack_o, bus.m0_data_o} !== {1'b1, rC}) begin failures++; $display("FAIL b2b_ack_c: got ack=%b data=%h expected 1/%h", bus.m0_ack_o, bus.m0_data_o, rC); end
        dropReq(0);
        expData[0] = rC;
        lastGrant  = 0;
        tick();
    endtask

    task automatic test_addr_hold();
        logic [DATA_W-1:0] d, r;
        logic stable;
        d = rand256(); r = rand256();
        setReq(1, 1'b1, 1'b1, 32'h1000, d);
        tick();
        stable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) setReq(1, 1'b1, 1'b0, 32'hDEAD_0000, rand256());
            if ({bus.mem_write_o, bus.mem_addr_o, bus.mem_data_o} !== {1'b1, 32'h1000, d}) stable = 1'b0;
            tick();
        end
        checks++; if (stable !== 1'b1) begin failures++; $display("FAIL hold_request: got a=%h w=%b expected a=00001000 w=1", bus.mem_addr_o, bus.mem_write_o); end
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = r;
        tick();
        bus.mem_ack_i  = 1'b0;
        checks++; if ({bus.m1_ack_o, bus.m1_data_o} !== {1'b1, r}) begin failures++; $display("FAIL hold_ack: got ack=%b data=%h expected 1/%h", bus.m1_ack_o, bus.m1_data_o, r); end
        dropReq(1);
        expData[1] = r;
        lastGrant  = 1;
        tick();
    endtask

    task automatic test_random();
        logic              pend [2];
        logic              pw   [2];
        logic [ADDR_W-1:0] pa   [2];
        logic [DATA_W-1:0] pd   [2];
        logic [DATA_W-1:0] rd, gotData, othData;
        logic [1:0]        expGrant;
        int w, lat, enC, ackS;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int round = 0; round < 60; round++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(0, 1) == 1) begin
                    pend[m] = 1'b1; pw[m] = 1'($urandom); pa[m] = $urandom; pd[m] = rand256();
                    setReq(m, 1'b1, pw[m], pa[m], pd[m]);
                end
            end
            // Stray memory acks while idle must be ignored.
            bus.mem_ack_i  = 1'($urandom_range(0, 1));
            bus.mem_data_i = rand256();
            if (pend[0] && pend[1]) w = (lastGrant == 0) ? 1 : 0;
            else if (pend[0])       w = 0;
            else if (pend[1])       w = 1;
            else                    w = -1;
            tick();
            bus.mem_ack_i = 1'b0;
            if (w < 0) begin
                checks++; if ({grant_o, bus.mem_enable_o, bus.m0_ack_o, bus.m1_ack_o} !== 5'b0) begin failures++; $display("FAIL rand_idle: got grant=%b en=%b expected all 0", grant_o, bus.mem_enable_o); end
                continue;
            end
            expGrant = (w == 0) ? 2'b01 : 2'b10;
            checks++; if (grant_o !== expGrant) begin failures++; $display("FAIL rand_grant: round %0d got %b expected %b", round, grant_o, expGrant); end
            checks++; if ({bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o, bus.mem_data_o} !== {1'b1, pw[w], pa[w], pd[w]}) begin failures++; $display("FAIL rand_request: round %0d got en=%b w=%b a=%h expected 1/%b/%h", round, bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o, pw[w], pa[w]); end
            lat = $urandom_range(1, 8);
            rd  = rand256();
            memRespond(lat, rd, enC, ackS);
            checks++; if ({enC, ackS} !== {lat, 32'd0}) begin failures++; $display("FAIL rand_busy: round %0d got en_cycles=%0d acks=%0d expected %0d/0", round, enC, ackS, lat); end
            checks++; if ({bus.m1_ack_o, bus.m0_ack_o, bus.mem_enable_o, timeout_o} !== {expGrant, 1'b0, expTimeout}) begin failures++; $display("FAIL rand_resp: round %0d got acks=%b en=%b to=%b expected %b/0/%b", round, {bus.m1_ack_o, bus.m0_ack_o}, bus.mem_enable_o, timeout_o, expGrant, expTimeout); end
            gotData = (w == 0) ? bus.m0_data_o : bus.m1_data_o;
            othData = (w == 0) ? bus.m1_data_o : bus.m0_data_o;
            checks++; if ({gotData, othData} !== {rd, expData[1-w]}) begin failures++; $display("FAIL rand_data: round %0d got %h/%h expected %h/%h", round, gotData, othData, rd, expData[1-w]); end
            expData[w] = rd;
            lastGrant  = w;
            pend[w]    = 1'b0;
            dropReq(w);
            if ($urandom_range(0, 3) == 0) begin
                pend[w] = 1'b1; pw[w] = 1'($urandom); pa[w] = $urandom; pd[w] = rand256();
                setReq(w, 1'b1, pw[w], pa[w], pd[w]);
            end
            bus.mem_ack_i  = 1'($urandom_range(0, 1));
            bus.mem_data_i = rand256();
            tick();
            bus.mem_ack_i = 1'b0;
            checks++; if ({grant_o, bus.m0_ack_o, bus.m1_ack_o} !== 4'b0) begin failures++; $display("FAIL rand_back_idle: round %0d got grant=%b acks=%b expected 0", round, grant_o, {bus.m0_ack_o, bus.m1_ack_o}); end
            checks++; if ({bus.m0_data_o, bus.m1_data_o} !== {expData[0], expData[1]}) begin failures++; $display("FAIL rand_data_hold: round %0d got %h/%h expected %h/%h", round, bus.m0_data_o, bus.m1_data_o, expData[0], expData[1]); end
        end
        dropReq(0);
        dropReq(1);
    endtask

    task automatic test_timeout();
        logic [DATA_W-1:0] r;
        logic seen, early;
        int enC, ackS;
        setReq(0, 1'b1, 1'b0, 32'h5000, rand256());
        tick();
        checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL to_grant: got %b expected 01", grant_o); end
        enC = 0; seen = 1'b0; early = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.m0_ack_o) begin seen = 1'b1; break; end
            if (bus.mem_enable_o) enC++;
            if (timeout_o) early = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL to_ack_missing: got no ack within 40 cycles, expected one"); end
        checks++; if (enC !== TIMEOUT) begin failures++; $display("FAIL to_busy_len: got %0d expected %0d", enC, TIMEOUT); end
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL to_early_flag: got early flag, expected none before expiry"); end
        checks++; if ({timeout_o, bus.mem_enable_o, bus.m1_ack_o} !== 3'b100) begin failures++; $display("FAIL to_resp: got to=%b en=%b ack1=%b expected 1/0/0", timeout_o, bus.mem_enable_o, bus.m1_ack_o); end
        checks++; if (bus.m0_data_o !== expData[0]) begin failures++; $display("FAIL to_data_kept: got %h expected %h", bus.m0_data_o, expData[0]); end
        dropReq(0);
        lastGrant  = 0;
        expTimeout = 1'b1;
        tick();
        checks++; if ({grant_o, bus.m0_ack_o} !== 3'b000) begin failures++; $display("FAIL to_idle: got grant=%b ack=%b expected 00/0", grant_o, bus.m0_ack_o); end
        r = rand256();
        setReq(1, 1'b1, 1'b0, 32'h6000, rand256());
        tick();
        memRespond(5, r, enC, ackS);
        checks++; if ({bus.m1_ack_o, bus.m1_data_o} !== {1'b1, r}) begin failures++; $display("FAIL to_next_txn: got ack=%b data=%h expected 1/%h", bus.m1_ack_o, bus.m1_data_o, r); end
        dropReq(1);
        expData[1] = r;
        lastGrant  = 1;
        tick();
        checks++; if (timeout_o !== expTimeout) begin failures++; $display("FAIL to_sticky: got %b expected %b", timeout_o, expTimeout); end
    endtask

    task automatic test_reset_mid_busy();
        logic [DATA_W-1:0] r0, r1;
        int enC, ackS;
        r0 = rand256(); r1 = rand256();
        setReq(0, 1'b1, 1'b1, 32'h7000, rand256());
        tick();
        checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL rstb_grant: got %b expected 01", grant_o); end
        tick(); tick(); tick();
        #3;
        rst_i = 1'b1;
        #1;
        checks++; if ({grant_o, timeout_o, bus.mem_enable_o, bus.mem_write_o} !== 5'b0) begin failures++; $display("FAIL rstb_async_ctrl: got grant=%b to=%b en=%b w=%b expected all 0", grant_o, timeout_o, bus.mem_enable_o, bus.mem_write_o); end
        checks++; if ({bus.mem_addr_o, bus.mem_data_o, bus.m0_data_o, bus.m1_data_o} !== '0) begin failures++; $display("FAIL rstb_async_data: got a=%h expected all 0", bus.mem_addr_o); end
        dropReq(0);
        bus.mem_ack_i = 1'b1;
        tick();
        tick();
        checks++; if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b00) begin failures++; $display("FAIL rstb_no_ack: got %b expected 00", {bus.m0_ack_o, bus.m1_ack_o}); end
        bus.mem_ack_i = 1'b0;
        rst_i = 1'b0;
        modelReset();
        setReq(0, 1'b1, 1'b0, 32'h8000, rand256());
        setReq(1, 1'b1, 1'b0, 32'h9000, rand256());
        tick();
        checks++; if ({grant_o, bus.mem_addr_o} !== {2'b01, 32'h8000}) begin failures++; $display("FAIL rstb_first_after: got grant=%b a=%h expected 01/00008000", grant_o, bus.mem_addr_o); end
        memRespond(2, r0, enC, ackS);
        checks++; if ({bus.m0_ack_o, bus.m0_data_o} !== {1'b1, r0}) begin failures++; $display("FAIL rstb_ack0: got ack=%b data=%h expected 1/%h", bus.m0_ack_o, bus.m0_data_o, r0); end
        dropReq(0);
        tick();
        tick();
        checks++; if (grant_o !== 2'b10) begin failures++; $display("FAIL rstb_second: got %b expected 10", grant_o); end
        memRespond(1, r1, enC, ackS);
        checks++; if ({bus.m1_ack_o, bus.m1_data_o, timeout_o} !== {1'b1, r1, expTimeout}) begin failures++; $display("FAIL rstb_ack1: got ack=%b to=%b expected 1/%b", bus.m1_ack_o, timeout_o, expTimeout); end
        dropReq(1);
        tick();
    endtask

    initial begin
        rst_i = 1'b1;
        idleInputs();
        modelReset();
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_addr_hold();
        test_random();
        test_timeout();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the design wedges somewhere unexpected.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected one");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
